// File: rtl/waveform_mode_controller.sv
// Front-panel controller for the function-generator waveform bank.
// Debounces the panel buttons, walks the waveform modes OFF -> SQR -> TRI -> SAW -> OFF,
// and defers every enable change and step change to a generator cycle boundary.

// Button conditioner: two-flop synchronizer, debounce counter and a one-cycle press pulse
// that fires in the cycle whose closing edge flips the debounced level high.
module WaveformButtonDebounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             flip;

  // Count consecutive cycles of disagreement; the last one accepts the new level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    flip    = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        flip    = 1'b1;
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  assign press_o = flip & sync2_q;

  // Synchronizer flops, debounced level and counter.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

module waveform_mode_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SYNC_TIMEOUT    = 4194304,
  parameter int unsigned STEP_W          = 8,
  parameter int unsigned STEP_MIN        = 1,
  parameter int unsigned STEP_MAX        = 255,
  parameter int unsigned STEP_RESET      = 16
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              Btn_Mode,
  input  logic              Btn_Up,
  input  logic              Btn_Down,
  input  logic              Wave_Sync,
  output logic              Enable_SW_1,
  output logic              Enable_SW_2,
  output logic              Enable_SW_3,
  output logic [STEP_W-1:0] Step,
  output logic              Busy
);

  localparam int unsigned TO_W = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
  localparam logic [TO_W-1:0]   TO_LAST      = TO_W'(SYNC_TIMEOUT - 1);
  localparam logic [STEP_W-1:0] STEP_MIN_V   = STEP_W'(STEP_MIN);
  localparam logic [STEP_W-1:0] STEP_MAX_V   = STEP_W'(STEP_MAX);
  localparam logic [STEP_W-1:0] STEP_RESET_V = STEP_W'(STEP_RESET);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_SQR,
    ST_TRI,
    ST_SAW,
    ST_DRAIN,
    ST_GAP
  } state_t;

  state_t            state_q;
  state_t            state_d;
  state_t            nextMode_q;
  state_t            nextMode_d;
  logic [TO_W-1:0]   waitCnt_q;
  logic [TO_W-1:0]   waitCnt_d;
  logic [2:0]        enable_q;
  logic [2:0]        enable_d;
  logic              busy_q;
  logic              busy_d;
  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] step_d;
  logic [STEP_W-1:0] stepPending_q;
  logic [STEP_W-1:0] stepPending_d;
  logic              modePress;
  logic              upPress;
  logic              downPress;

  WaveformButtonDebounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uModeBtn (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .btn_i  (Btn_Mode),
    .press_o(modePress)
  );

  WaveformButtonDebounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uUpBtn (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .btn_i  (Btn_Up),
    .press_o(upPress)
  );

  WaveformButtonDebounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDownBtn (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .btn_i  (Btn_Down),
    .press_o(downPress)
  );

  // Mode sequencing: presses only act in steady states; DRAIN waits for a cycle boundary.
  always_comb begin
    state_d    = state_q;
    nextMode_d = nextMode_q;
    waitCnt_d  = waitCnt_q;
    case (state_q)
      ST_OFF: begin
        if (modePress) begin
          nextMode_d = ST_SQR;
          state_d    = ST_GAP;
        end
      end
      ST_SQR: begin
        if (modePress) begin
          nextMode_d = ST_TRI;
          state_d    = ST_DRAIN;
          waitCnt_d  = '0;
        end
      end
      ST_TRI: begin
        if (modePress) begin
          nextMode_d = ST_SAW;
          state_d    = ST_DRAIN;
          waitCnt_d  = '0;
        end
      end
      ST_SAW: begin
        if (modePress) begin
          nextMode_d = ST_OFF;
          state_d    = ST_DRAIN;
          waitCnt_d  = '0;
        end
      end
      ST_DRAIN: begin
        if (Wave_Sync || (waitCnt_q == TO_LAST)) begin
          state_d   = (nextMode_q == ST_OFF) ? ST_OFF : ST_GAP;
          waitCnt_d = '0;
        end else begin
          waitCnt_d = waitCnt_q + TO_W'(1);
        end
      end
      ST_GAP: begin
        state_d = nextMode_q;
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  // Enables decode the upcoming state; DRAIN holds whichever enable was already on.
  always_comb begin
    enable_d = 3'b000;
    case (state_d)
      ST_SQR:   enable_d = 3'b001;
      ST_TRI:   enable_d = 3'b010;
      ST_SAW:   enable_d = 3'b100;
      ST_DRAIN: enable_d = enable_q;
      default:  enable_d = 3'b000;
    endcase
    busy_d = (state_d == ST_DRAIN) || (state_d == ST_GAP);
  end

  // Step bookkeeping: pending value follows the buttons, the live value waits for a safe point.
  always_comb begin
    stepPending_d = stepPending_q;
    if (upPress && !downPress && (stepPending_q < STEP_MAX_V)) begin
      stepPending_d = stepPending_q + STEP_W'(1);
    end else if (downPress && !upPress && (stepPending_q > STEP_MIN_V)) begin
      stepPending_d = stepPending_q - STEP_W'(1);
    end
    step_d = step_q;
    if ((state_q == ST_OFF) || (state_q == ST_GAP) || Wave_Sync) begin
      step_d = stepPending_q;
    end
  end

  // Controller registers.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q       <= ST_OFF;
      nextMode_q    <= ST_OFF;
      waitCnt_q     <= '0;
      enable_q      <= 3'b000;
      busy_q        <= 1'b0;
      step_q        <= STEP_RESET_V;
      stepPending_q <= STEP_RESET_V;
    end else begin
      state_q       <= state_d;
      nextMode_q    <= nextMode_d;
      waitCnt_q     <= waitCnt_d;
      enable_q      <= enable_d;
      busy_q        <= busy_d;
      step_q        <= step_d;
      stepPending_q <= stepPending_d;
    end
  end

  assign Enable_SW_1 = enable_q[0];
  assign Enable_SW_2 = enable_q[1];
  assign Enable_SW_3 = enable_q[2];
  assign Step        = step_q;
  assign Busy        = busy_q;

endmodule

// File: doc/waveform_mode_controller.md
# waveform_mode_controller

Front-panel controller for the function-generator waveform datapath. Debounces the mode and frequency buttons. Selects exactly one waveform generator (square, triangle, sawtooth) or none through one-hot enables, and schedules every mode switch and step change on the active generator's cycle boundary so the output never glitches mid-period. It sits between the board buttons and the generator bank, and it drives the generator enable inputs, including `Enable_SW_2` for the triangle generator.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles needed to accept a button level (20 ms at 50 MHz).
- `SYNC_TIMEOUT`, default 4194304: maximum cycles to wait for `Wave_Sync` before a forced switch.
- `STEP_W`, default 8: width of the frequency step.
- `STEP_MIN`, default 1; `STEP_MAX`, default 255; `STEP_RESET`, default 16.

Ports:
- `sysclk`, in, 1: system clock. One clock for the whole block.
- `rst_n`, in, 1: synchronous, active-low reset.
- `Btn_Mode`, in, 1: raw mode button, active-high, asynchronous to `sysclk`.
- `Btn_Up`, in, 1: raw step-up button, active-high, asynchronous.
- `Btn_Down`, in, 1: raw step-down button, active-high, asynchronous.
- `Wave_Sync`, in, 1: one-cycle pulse from the active generator at phase zero.
- `Enable_SW_1`, out, 1: square generator enable.
- `Enable_SW_2`, out, 1: triangle generator enable.
- `Enable_SW_3`, out, 1: sawtooth generator enable.
- `Step`, out, STEP_W: phase increment applied by all generators.
- `Busy`, out, 1: a mode switch is pending.

## Operation

Button conditioning (identical per button):
- Two-flop synchronizer feeds a debounce counter.
- The counter increments while the synchronized level differs from the debounced level. Any matching cycle clears it.
- When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- A rising edge of the debounced level produces a one-cycle press event.

Mode FSM states:
- OFF, SQR, TRI, SAW: steady states.
- DRAIN: waiting for `Wave_Sync` before leaving the current mode.
- GAP: one cycle with all enables low.
- Register `next_mode` holds the destination. The cyclic order is OFF → SQR → TRI → SAW → OFF.

Transitions:
- OFF + Mode press → GAP (next_mode = SQR) → SQR.
- SQR/TRI/SAW + Mode press → DRAIN. The current enable stays high.
- DRAIN leaves on `Wave_Sync`, or when its wait counter reaches SYNC_TIMEOUT:
  - to GAP, then to next_mode, when next_mode is not OFF;
  - directly to OFF, when next_mode is OFF.
- Mode presses in DRAIN or GAP are discarded. They are not queued.

Outputs:
- Enables are registered, one-hot-or-zero decodes of the state. In DRAIN the previous mode's enable remains high.
- Two enables are never high in the same cycle.
- `Busy` = 1 in DRAIN and GAP.

Step control:
- `step_pending` is updated on Up press (+1, saturating at STEP_MAX) and Down press (−1, saturating at STEP_MIN).
- Up and Down presses in the same cycle leave it unchanged.
- `Step` loads `step_pending`:
  - immediately (next edge) when the state is OFF;
  - otherwise only on a `Wave_Sync` cycle.
- `Step` is also loaded in GAP, so a new mode starts at the current step.

## Timing

- Reset (`rst_n` low at a `sysclk` edge) forces, at that edge:
  - state OFF;
  - all enables 0;
  - `Busy` 0;
  - `Step` and `step_pending` = STEP_RESET;
  - all debounced levels, counters and synchronizers 0.
- Reset mid-DRAIN abandons the switch. No enable stays high.
- Button latency: a press event occurs DEBOUNCE_CYCLES + 2 cycles after the raw level settles high at the input.
- Glitches shorter than DEBOUNCE_CYCLES produce no event.
- OFF → SQR: GAP in the cycle after the event; `Enable_SW_1` high 2 cycles after the event.
- Active mode → next:
  - `Busy` rises 1 cycle after the event.
  - The old enable falls the cycle after `Wave_Sync` is sampled in DRAIN.
  - The new enable rises one cycle later.
  - `Busy` falls with the new enable rising.
- A `Wave_Sync` already high in the event cycle does not count; only a sync seen in DRAIN does.
- Timeout: DRAIN lasts exactly SYNC_TIMEOUT cycles when no sync arrives.
- `Wave_Sync` is ignored in OFF and GAP for state purposes.

## Test plan

Bench settings: DEBOUNCE_CYCLES=4, SYNC_TIMEOUT=16, 20 ns clock.

- Reset check: hold `rst_n`=0 for 3 cycles, release → enables 000, `Step`=16, `Busy`=0.
- Debounce: pulse `Btn_Mode` for 3 cycles → no event, state OFF. Hold it high 10 cycles → exactly one event; `Enable_SW_1` rises 2 cycles later.
- Synced switch: in SQR, press Mode, then `Wave_Sync` 7 cycles into DRAIN → `Enable_SW_1` falls, next cycle all low, next `Enable_SW_2`=1, `Busy` 1→0.
- Timeout: in TRI, press Mode with no `Wave_Sync` → after 16 DRAIN cycles, GAP, then `Enable_SW_3`=1. SAW + Mode + sync → OFF with no GAP.
- Step saturation: in OFF, 20 Down presses → `Step`=1. Then in SQR, 3 Up presses → `Step` stays 1 until `Wave_Sync`, then 4. Simultaneous Up+Down → no change.
- Mid-drain reset: in DRAIN, assert `rst_n`=0 for one edge → enables 000, `Busy`=0, `Step`=16.
